// File: rtl/adder_result_buffer.sv
// adder_result_buffer: FIFO of adder results with registered head outputs and overflow statistics
module adder_result_buffer #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_result,
    input  logic             in_carryout,
    input  logic             in_overflow,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic             out_carryout,
    output logic             out_overflow,
    output logic             out_zero,
    output logic             out_negative,
    input  logic             clear_stats,
    output logic             sticky_overflow,
    output logic [CNT_W-1:0] ovf_count
);
    localparam int AW = $clog2(DEPTH);
    logic [31:0] resultMem [DEPTH];
    logic [3:0] flagMem [DEPTH];
    logic [AW-1:0] wrPtr, rdPtr;
    logic [AW:0] count;
    logic push, pop, ovfPush;
    assign in_ready = count != (AW+1)'(DEPTH);
    assign out_valid = count != '0;
    assign push = in_valid && in_ready;
    assign pop = out_valid && out_ready;
    assign ovfPush = push && in_overflow;
    // flags are derived once at push time so the head outputs stay purely registered
    always_ff @(posedge clk)
        if (push) begin
            resultMem[wrPtr] <= in_result;
            flagMem[wrPtr] <= {in_carryout, in_overflow, in_result == 32'd0, in_result[31]};
        end
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop) rdPtr <= rdPtr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            sticky_overflow <= 1'b0;
            ovf_count <= '0;
        end else if (clear_stats) begin
            sticky_overflow <= ovfPush;
            ovf_count <= CNT_W'(ovfPush);
        end else if (ovfPush) begin
            sticky_overflow <= 1'b1;
            if (ovf_count != '1) ovf_count <= ovf_count + 1'b1;
        end
    assign out_result = out_valid ? resultMem[rdPtr] : 32'd0;
    assign {out_carryout, out_overflow, out_zero, out_negative} = out_valid ? flagMem[rdPtr] : 4'd0;
endmodule

// File: tb/tb_adder_result_buffer.sv
// tb_adder_result_buffer: directed scenarios plus randomized traffic against a queue-based model
module tb_adder_result_buffer;
    localparam int DEPTH = 2;
    localparam int CNT_W = 2;
    logic clk = 0, reset = 1, in_valid = 0, out_ready = 0, clear_stats = 0;
    logic in_carryout = 0, in_overflow = 0;
    logic [31:0] in_result = 0;
    logic in_ready, out_valid, out_carryout, out_overflow, out_zero, out_negative, sticky_overflow;
    logic [31:0] out_result;
    logic [CNT_W-1:0] ovf_count;
    int compared = 0, mismatched = 0;
    bit checkEn = 0;

    adder_result_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_carryout(in_carryout), .in_overflow(in_overflow),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_carryout(out_carryout), .out_overflow(out_overflow), .out_zero(out_zero),
        .out_negative(out_negative), .clear_stats(clear_stats),
        .sticky_overflow(sticky_overflow), .ovf_count(ovf_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct { logic [31:0] r; logic c; logic o; } entry_t;
    entry_t q[$];
    bit mSticky;
    int mCnt;

    always @(posedge clk or posedge reset) begin
        bit push, pop, ovf;
        if (reset) begin
            q.delete();
            mSticky = 0;
            mCnt = 0;
        end else begin
            push = in_valid && q.size() < DEPTH;
            pop = q.size() > 0 && out_ready;
            ovf = push && in_overflow;
            if (pop) void'(q.pop_front());
            if (push) q.push_back('{in_result, in_carryout, in_overflow});
            if (clear_stats) begin
                mSticky = ovf;
                mCnt = ovf ? 1 : 0;
            end else if (ovf) begin
                mSticky = 1;
                if (mCnt < (1 << CNT_W) - 1) mCnt++;
            end
        end
    end

    always @(negedge clk) if (checkEn) begin
        chk("out_valid", out_valid, q.size() > 0);
        chk("in_ready", in_ready, q.size() < DEPTH);
        chk("sticky", sticky_overflow, mSticky);
        chk("ovf_count", ovf_count, mCnt);
        if (q.size() > 0) begin
            chk("out_result", out_result, q[0].r);
            chk("out_carryout", out_carryout, q[0].c);
            chk("out_overflow", out_overflow, q[0].o);
            chk("out_zero", out_zero, q[0].r == 0);
            chk("out_negative", out_negative, q[0].r >= 32'h8000_0000);
        end else if (reset) begin
            chk("rst_result", out_result, 0);
            chk("rst_flags", {out_carryout, out_overflow, out_zero, out_negative}, 0);
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_cnt", ovf_count, 0);
        chk("rst_res", out_result, 0);
        reset = 0;
        checkEn = 1;
        // single push, held while out_ready=0
        in_valid = 1; in_result = 32'h5;
        step();
        in_valid = 0;
        chk("lat_valid", out_valid, 1);
        chk("lat_result", out_result, 32'h5);
        chk("lat_flags", {out_zero, out_negative}, 0);
        repeat (3) step();
        chk("hold_result", out_result, 32'h5);
        chk("hold_valid", out_valid, 1);
        out_ready = 1; step(); out_ready = 0;
        // fill, then pop one
        in_valid = 1; in_result = 32'h7FFF_FFFF;
        step();
        in_result = 32'h8000_0000; in_overflow = 1;
        step();
        in_valid = 0; in_overflow = 0;
        chk("full_ready", in_ready, 0);
        out_ready = 1; step(); out_ready = 0;
        chk("pop_ready", in_ready, 1);
        chk("neg_result", out_result, 32'h8000_0000);
        chk("neg_flag", out_negative, 1);
        chk("ovf_flag", out_overflow, 1);
        chk("sticky_set", sticky_overflow, 1);
        chk("cnt_one", ovf_count, 1);
        out_ready = 1; step(); out_ready = 0;
        // zero result with carry
        in_valid = 1; in_result = 0; in_carryout = 1;
        step();
        in_valid = 0; in_carryout = 0;
        chk("zero_flag", out_zero, 1);
        chk("carry_flag", out_carryout, 1);
        chk("carry_cnt", ovf_count, 1);
        out_ready = 1; step();
        // streaming 1..10
        in_valid = 1;
        for (int i = 1; i <= 10; i++) begin
            in_result = i;
            step();
            chk("stream_result", out_result, i);
            chk("stream_ready", in_ready, 1);
        end
        in_valid = 0; step();
        // saturation and clear with simultaneous overflow push
        in_valid = 1; in_overflow = 1; in_result = 32'h1234;
        repeat (5) step();
        chk("sat_cnt", ovf_count, 3);
        clear_stats = 1; step(); clear_stats = 0;
        chk("clr_cnt", ovf_count, 1);
        chk("clr_sticky", sticky_overflow, 1);
        in_valid = 0; in_overflow = 0;
        repeat (3) step();
        out_ready = 0;
        // async reset while full
        in_valid = 1; in_result = 32'h77;
        repeat (2) step();
        in_valid = 0;
        chk("pre_rst_full", in_ready, 0);
        #2 reset = 1;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_ready", in_ready, 1);
        chk("arst_cnt", ovf_count, 0);
        chk("arst_sticky", sticky_overflow, 0);
        chk("arst_result", out_result, 0);
        step();
        reset = 0;
        in_valid = 1; in_result = 32'hA;
        step();
        in_valid = 0;
        chk("post_rst_head", out_result, 32'hA);
        chk("post_rst_valid", out_valid, 1);
        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            in_valid = $urandom_range(0, 1);
            out_ready = $urandom_range(0, 2) != 0;
            clear_stats = $urandom_range(0, 15) == 0;
            in_overflow = $urandom_range(0, 3) == 0;
            in_carryout = $urandom_range(0, 1);
            case ($urandom_range(0, 3))
                0: in_result = 0;
                1: in_result = 32'h8000_0000 | $urandom;
                default: in_result = $urandom;
            endcase
            reset = $urandom_range(0, 199) == 0;
            step();
        end
        reset = 0;
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/adder_result_buffer.md
ADDER_RESULT_BUFFER -- requirements
Module: adder_result_buffer

Interface
REQ-001 Parameter DEPTH, default 2, number of FIFO entries; SHALL be a power of two >= 2.
REQ-002 Parameter CNT_W, default 8, width of overflow event counter.
REQ-003 clk  input  1  single clock; all state SHALL update on rising edge only.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  upstream adder result valid.
REQ-006 in_ready  output  1  buffer can accept an entry.
REQ-007 in_result  input  32  adder sum.
REQ-008 in_carryout  input  1  adder carry out of bit 31.
REQ-009 in_overflow  input  1  adder signed overflow.
REQ-010 out_valid  output  1  head entry valid.
REQ-011 out_ready  input  1  downstream accepts head entry.
REQ-012 out_result  output  32  head sum.
REQ-013 out_carryout, out_overflow  output  1 each  head carry/overflow.
REQ-014 out_zero  output  1  head sum == 0.
REQ-015 out_negative  output  1  head sum bit 31.
REQ-016 clear_stats  input  1  synchronous clear of sticky flag and counter.
REQ-017 sticky_overflow  output  1  any overflow accepted since last clear/reset.
REQ-018 ovf_count  output  CNT_W  accepted overflow events, saturating.

Function
REQ-019 Push SHALL occur on a rising edge where in_valid && in_ready; pop where out_valid && out_ready.
REQ-020 in_ready SHALL equal !full and SHALL NOT depend combinationally on out_ready or in_valid.
REQ-021 out_valid SHALL equal !empty; out_* SHALL be driven from registered head storage (no in->out combinational path).
REQ-022 Latency: an entry pushed into an empty buffer SHALL appear with out_valid=1 in the cycle after the push edge.
REQ-023 Entries SHALL pop in push order; read/write pointers SHALL wrap from DEPTH-1 to 0.
REQ-024 Occupancy SHALL range 0..DEPTH; simultaneous push and pop SHALL leave occupancy unchanged, including at occupancy DEPTH-1 and 1.
REQ-025 When full, push is impossible (in_ready=0); a pop in that cycle SHALL raise in_ready the next cycle.
REQ-026 When empty, out_ready SHALL have no effect; pop SHALL NOT underflow pointers.
REQ-027 out_zero and out_negative SHALL be computed at push time and stored with the entry.
REQ-028 While out_valid && !out_ready, all out_* SHALL hold stable.
REQ-029 On a push with in_overflow=1: sticky_overflow SHALL set and ovf_count SHALL increment by 1, saturating at 2^CNT_W-1.
REQ-030 clear_stats=1 SHALL zero sticky_overflow and ovf_count at that edge; if an overflow push occurs on the same edge, result SHALL be sticky_overflow=1, ovf_count=1.
REQ-031 in_carryout SHALL be stored and reported only; it SHALL NOT affect statistics.

Reset
REQ-032 reset=1 SHALL immediately, without a clock edge, force: pointers and occupancy 0, out_valid=0, in_ready=1, sticky_overflow=0, ovf_count=0.
REQ-033 out_result, out_carryout, out_overflow, out_zero, out_negative SHALL read 0 during reset.
REQ-034 Reset asserted mid-operation SHALL discard all stored entries; first push after deassertion SHALL be head.
REQ-035 No push or pop SHALL be accepted on an edge where reset=1.

Verification
REQ-036 Push 0x00000005 (ovf=0) into empty, out_ready=0 -> next cycle out_valid=1, out_result=0x00000005, out_zero=0, out_negative=0; held stable 3 cycles.
REQ-037 DEPTH=2: push 0x7FFFFFFF, 0x80000000 (ovf=1) with out_ready=0 -> in_ready=0 after second push; pop one -> in_ready=1 next cycle; head 0x80000000 shows out_negative=1, out_overflow=1, sticky_overflow=1, ovf_count=1.
REQ-038 Push 0x00000000 with carryout=1 -> out_zero=1, out_carryout=1, ovf_count unchanged.
REQ-039 Continuous in_valid=1, out_ready=1 for 10 cycles with sequence 1..10 -> outputs 1..10 in order, one per cycle after first, occupancy never exceeds 1, pointers wrap.
REQ-040 CNT_W=2: push 5 overflow entries -> ovf_count=3; clear_stats with simultaneous overflow push -> ovf_count=1, sticky_overflow=1.
REQ-041 Full buffer, assert reset between edges -> out_valid=0, in_ready=1, ovf_count=0 immediately; post-reset push 0x0000000A appears as head.
